usb_fs_tx_serializer: RTL and testbench

// - Parametrised USB full-speed bit-serial transmitter: byte stream in (valid/ready), D+/D- line out.
// - Generates SYNC, bit stuffing, NRZI and EOP.
// - Drives the upstream port in the usbdev design and doubles as host-side stimulus source on the bench.
// - Generalises the fixed 8-bit SYNC / 2-bit EOP line to configurable bit rate, SYNC length, EOP length, stuffing run.

---
 rtl/usb_fs_tx_serializer.sv | 206 ++++++++++++++++++++
 tb/tb_usb_fs_tx_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_tx_serializer.sv
// USB full-speed bit-serial transmitter: byte stream in, NRZI D+/D- out with
// SYNC, bit stuffing and EOP. Line outputs only change on bit-tick wrap.
module usb_fs_tx_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_BITS    = 8,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2,
  parameter int EOP_J_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       dp_out,
  output logic       dn_out,
  output logic       oe,
  output logic       busy,
  output logic       underrun
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_EOP_SE0 = 3'd3;
  localparam logic [2:0] ST_EOP_J   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [3:0]    ones_q, ones_d;
  logic [7:0]    shift_q, shift_d;
  logic          shift_last_q, shift_last_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_full_q, hold_full_d;
  logic          last_acc_q, last_acc_d;
  logic          dp_q, dp_d;
  logic          dn_q, dn_d;
  logic          underrun_q, underrun_d;

  logic accept, bit_end, emit, emit_bit, reload, to_eop;

  assign in_ready = !rst && !hold_full_q && !last_acc_q &&
                    ((state_q == ST_IDLE) || (state_q == ST_DATA));
  assign accept   = in_valid && in_ready;
  assign bit_end  = (tick_q == TW'(CLKS_PER_BIT - 1));

  assign dp_out   = dp_q;
  assign dn_out   = dn_q;
  assign oe       = (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign underrun = underrun_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ones_d       = ones_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    last_acc_d   = last_acc_q;
    dp_d         = dp_q;
    dn_d         = dn_q;
    underrun_d   = 1'b0;
    emit         = 1'b0;
    emit_bit     = 1'b0;
    reload       = 1'b0;
    to_eop       = 1'b0;

    if (state_q == ST_IDLE || bit_end) tick_d = '0;
    else                               tick_d = tick_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
          emit    = 1'b1;
        end
      end
      ST_SYNC: begin
        if (bit_end) begin
          if (int'(cnt_q) < SYNC_BITS - 1) begin
            cnt_d    = cnt_q + 6'd1;
            emit     = 1'b1;
            emit_bit = (int'(cnt_q) == SYNC_BITS - 2);
          end else begin
            state_d = ST_DATA;
            reload  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // A stuffed bit is just an emitted 0 that leaves the shifter alone
        if (bit_end) begin
          if (int'(ones_q) >= STUFF_LEN) begin
            emit = 1'b1;
          end else if (cnt_q != 6'd7) begin
            cnt_d    = cnt_q + 6'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            emit     = 1'b1;
            emit_bit = shift_q[1];
          end else if (shift_last_q) begin
            to_eop = 1'b1;
          end else if (hold_full_q) begin
            reload = 1'b1;
          end else begin
            to_eop     = 1'b1;
            underrun_d = 1'b1;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_end) begin
          if (int'(cnt_q) == EOP_SE0_BITS - 1) begin
            state_d = ST_EOP_J;
            cnt_d   = '0;
            dp_d    = 1'b1;
            dn_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_end) begin
          if (int'(cnt_q) == EOP_J_BITS - 1) begin
            state_d    = ST_IDLE;
            last_acc_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reload) begin
      cnt_d        = '0;
      shift_d      = hold_q;
      shift_last_d = hold_last_q;
      hold_full_d  = 1'b0;
      emit         = 1'b1;
      emit_bit     = hold_q[0];
    end
    if (to_eop) begin
      state_d = ST_EOP_SE0;
      cnt_d   = '0;
      dp_d    = 1'b0;
      dn_d    = 1'b0;
    end
    if (emit) begin
      if (!emit_bit) begin
        dp_d = ~dp_q;
        dn_d = ~dn_q;
      end
      ones_d = emit_bit ? ones_q + 4'd1 : '0;
    end
    // Accept after reload so a same-cycle reload sees the old holding byte
    if (accept) begin
      hold_d      = in_data;
      hold_last_d = in_last;
      hold_full_d = 1'b1;
      if (in_last) last_acc_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      cnt_q        <= '0;
      ones_q       <= '0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      last_acc_q   <= 1'b0;
      dp_q         <= 1'b1;
      dn_q         <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      cnt_q        <= cnt_d;
      ones_q       <= ones_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      last_acc_q   <= last_acc_d;
      dp_q         <= dp_d;
      dn_q         <= dn_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_usb_fs_tx_serializer.sv
// Bench for usb_fs_tx_serializer: two parameterisations driven from one sequence,
// line output compared per cycle against a bit-level packet model.
module tb_usb_fs_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  int         sel;

  logic vA, rdyA, dpA, dnA, oeA, busyA, undA;
  logic vB, rdyB, dpB, dnB, oeB, busyB, undB;
  logic o_rdy, o_dp, o_dn, o_oe, o_busy, o_und;

  int cfg_cpb, cfg_sync, cfg_stuff, cfg_se0, cfg_j;
  int errors = 0;
  int checks = 0;

  logic [7:0] pkt[8];
  logic [1:0] syms[$];
  int         se0_idx;

  always #5 clk = ~clk;

  assign vA = in_valid && (sel == 0);
  assign vB = in_valid && (sel == 1);

  usb_fs_tx_serializer #(
    .CLKS_PER_BIT(4), .SYNC_BITS(8), .STUFF_LEN(6), .EOP_SE0_BITS(2), .EOP_J_BITS(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vA), .in_last(in_last),
    .in_ready(rdyA), .dp_out(dpA), .dn_out(dnA), .oe(oeA), .busy(busyA), .underrun(undA)
  );

  usb_fs_tx_serializer #(
    .CLKS_PER_BIT(2), .SYNC_BITS(32), .STUFF_LEN(6), .EOP_SE0_BITS(3), .EOP_J_BITS(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vB), .in_last(in_last),
    .in_ready(rdyB), .dp_out(dpB), .dn_out(dnB), .oe(oeB), .busy(busyB), .underrun(undB)
  );

  always_comb begin
    o_rdy  = (sel == 0) ? rdyA  : rdyB;
    o_dp   = (sel == 0) ? dpA   : dpB;
    o_dn   = (sel == 0) ? dnA   : dnB;
    o_oe   = (sel == 0) ? oeA   : oeB;
    o_busy = (sel == 0) ? busyA : busyB;
    o_und  = (sel == 0) ? undA  : undB;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Packet as line symbols {dp,dn}: SYNC, stuffed NRZI data, SE0s, Js
  task automatic build_model(input int nb);
    bit level;
    bit b;
    int ones;
    syms.delete();
    level = 1'b1;
    for (int i = 0; i < cfg_sync; i++) begin
      b = (i == cfg_sync - 1);
      if (!b) level = !level;
      syms.push_back({level, !level});
    end
    ones = 1;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) begin
        b = pkt[k][j];
        if (b) ones++;
        else begin
          ones  = 0;
          level = !level;
        end
        syms.push_back({level, !level});
        if (ones == cfg_stuff) begin
          level = !level;
          syms.push_back({level, !level});
          ones = 0;
        end
      end
    end
    se0_idx = syms.size();
    for (int i = 0; i < cfg_se0; i++) syms.push_back(2'b00);
    for (int i = 0; i < cfg_j; i++)   syms.push_back(2'b10);
  endtask

  task automatic run_packet(input int nb, input bit withhold, input int abort_at);
    int  total;
    int  sent;
    int  und_at;
    bit  acc;
    logic [1:0] s;
    build_model(withhold ? 1 : nb);
    total  = syms.size() * cfg_cpb;
    und_at = se0_idx * cfg_cpb;
    sent   = 0;
    @(negedge clk);
    check("idle_ready", int'(o_rdy), 1);
    in_data  = pkt[0];
    in_last  = (nb == 1);
    in_valid = 1'b1;
    acc      = o_rdy;
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      if (acc) sent++;
      if (n == abort_at) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_dp", int'(o_dp), 1);
        check("rst_dn", int'(o_dn), 0);
        check("rst_oe", int'(o_oe), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_underrun", int'(o_und), 0);
        check("rst_ready", int'(o_rdy), 0);
        rst = 1'b0;
        return;
      end
      s = syms[n / cfg_cpb];
      check("line_dp", int'(o_dp), int'(s[1]));
      check("line_dn", int'(o_dn), int'(s[0]));
      check("oe_on", int'(o_oe), 1);
      check("busy_on", int'(o_busy), 1);
      check("underrun", int'(o_und), (withhold && n == und_at) ? 1 : 0);
      if (!withhold && sent == nb) check("ready_after_last", int'(o_rdy), 0);
      if (withhold && n >= und_at) check("late_refused", int'(o_rdy), 0);
      in_valid = 1'b0;
      if (sent < nb && (!withhold || n >= und_at)) begin
        in_valid = 1'b1;
        in_data  = pkt[sent];
        in_last  = (sent == nb - 1);
      end
      acc = in_valid && o_rdy;
    end
    @(negedge clk);
    if (acc) sent++;
    in_valid = 1'b0;
    check("end_oe", int'(o_oe), 0);
    check("end_busy", int'(o_busy), 0);
    check("end_dp", int'(o_dp), 1);
    check("end_dn", int'(o_dn), 0);
    check("end_underrun", int'(o_und), 0);
    check("end_ready", int'(o_rdy), 1);
    check("bytes_accepted", sent, withhold ? 1 : nb);
  endtask

  initial begin
    int nb;
    sel       = 0;
    cfg_cpb   = 4;
    cfg_sync  = 8;
    cfg_stuff = 6;
    cfg_se0   = 2;
    cfg_j     = 1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_dp", int'(o_dp), 1);
    check("reset_dn", int'(o_dn), 0);
    check("reset_oe", int'(o_oe), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_underrun", int'(o_und), 0);
    check("reset_ready", int'(o_rdy), 0);
    rst = 1'b0;

    pkt[0] = 8'hFF;
    run_packet(1, 1'b0, -1);
    pkt[0] = 8'h00;
    run_packet(1, 1'b0, -1);
    pkt[0] = 8'hA5; pkt[1] = 8'hC3; pkt[2] = 8'h7E;
    run_packet(3, 1'b0, -1);
    pkt[0] = 8'($urandom); pkt[1] = 8'($urandom);
    run_packet(2, 1'b1, -1);
    pkt[0] = 8'hFF;
    run_packet(1, 1'b0, (8 + 5) * 4 + 1);
    pkt[0] = 8'hFF;
    run_packet(1, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      nb = int'($urandom_range(1, 4));
      for (int k = 0; k < nb; k++) pkt[k] = 8'($urandom);
      run_packet(nb, 1'b0, -1);
    end

    sel       = 1;
    cfg_cpb   = 2;
    cfg_sync  = 32;
    cfg_se0   = 3;
    pkt[0]    = 8'h01;
    run_packet(1, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      nb = int'($urandom_range(1, 3));
      for (int k = 0; k < nb; k++) pkt[k] = 8'($urandom);
      run_packet(nb, 1'b0, -1);
    end
    pkt[0] = 8'($urandom); pkt[1] = 8'($urandom);
    run_packet(2, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
